alu_issue_ctrl: RTL and testbench

//  Sequential issue/capture stage directly upstream of operaciones_alu. Accepts one ALU

---
 rtl/alu_issue_ctrl_if.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-side and response signals of the ALU issue/capture stage.
// master = controller side, slave = surrounding datapath / ALU / consumer.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op_code;
    logic [WIDTH-1:0] alu_result;
    logic [1:0]       alu_comp;
    logic             alu_carry;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [1:0]       out_comp;
    logic             out_carry;
    logic [3:0]       out_op;
    logic             out_err;
    logic             flag_c;
    logic [1:0]       flag_cmp;

    modport master (
        input  in_valid, in_a, in_b, in_op, alu_result, alu_comp, alu_carry, out_ready,
        output in_ready, alu_a, alu_b, alu_op_code, out_valid, out_result, out_comp,
               out_carry, out_op, out_err, flag_c, flag_cmp
    );

    modport slave (
        output in_valid, in_a, in_b, in_op, alu_result, alu_comp, alu_carry, out_ready,
        input  in_ready, alu_a, alu_b, alu_op_code, out_valid, out_result, out_comp,
               out_carry, out_op, out_err, flag_c, flag_cmp
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage in front of the ALU: response valid SETTLE_CYCLES+1 cycles after accept
// (1 for illegal ops); one command in flight, in_ready low until the response is taken.
module alu_issue_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.master  bus
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_issue_ctrl: SETTLE_CYCLES must be within 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_op_q;
    logic [WIDTH-1:0] out_result_q;
    logic [1:0]       out_comp_q;
    logic             out_carry_q;
    logic [3:0]       out_op_q;
    logic             out_err_q;
    logic             flag_c_q;
    logic [1:0]       flag_cmp_q;

    logic accept;
    logic op_illegal;
    logic capture;

    // Legal op codes are 0000..1000.
    assign op_illegal = bus.in_op[3] & (|bus.in_op[2:0]);
    assign accept     = (state_q == IDLE) & in_ready_q & bus.in_valid;
    assign capture    = (state_q == DRIVE) & (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = op_illegal ? HOLD : DRIVE;
            DRIVE:   if (capture) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is its own flop so it reads 0 while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 4'd0;
            out_result_q <= '0;
            out_comp_q   <= 2'd0;
            out_carry_q  <= 1'b0;
            out_op_q     <= 4'd0;
            out_err_q    <= 1'b0;
            flag_c_q     <= 1'b0;
            flag_cmp_q   <= 2'd0;
        end else begin
            if (accept && !op_illegal) begin
                alu_a_q  <= bus.in_a;
                alu_b_q  <= bus.in_b;
                alu_op_q <= bus.in_op;
                cnt_q    <= CNT_INIT;
            end else if (state_q == DRIVE && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end

            // Illegal ops never reach the ALU; answer with a zeroed error response.
            if (accept && op_illegal) begin
                out_result_q <= '0;
                out_comp_q   <= 2'd0;
                out_carry_q  <= 1'b0;
                out_op_q     <= bus.in_op;
                out_err_q    <= 1'b1;
            end

            if (capture) begin
                out_result_q <= bus.alu_result;
                out_comp_q   <= bus.alu_comp;
                out_carry_q  <= bus.alu_carry;
                out_op_q     <= alu_op_q;
                out_err_q    <= 1'b0;
                if (alu_op_q == 4'b0000 || alu_op_q == 4'b0010) flag_c_q <= bus.alu_carry;
                if (alu_op_q == 4'b1000) flag_cmp_q <= bus.alu_comp;
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op_code = alu_op_q;
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.out_result  = out_result_q;
    assign bus.out_comp    = out_comp_q;
    assign bus.out_carry   = out_carry_q;
    assign bus.out_op      = out_op_q;
    assign bus.out_err     = out_err_q;
    assign bus.flag_c      = flag_c_q;
    assign bus.flag_cmp    = flag_cmp_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (settle 1 and 3) share one command stream,
// each with a behavioural ALU model on its alu_* port.
module tb_alu_issue_ctrl;
    localparam int W = 32;

    typedef struct packed {
        logic         in_ready;
        logic         out_valid;
        logic [W-1:0] out_result;
        logic [1:0]   out_comp;
        logic         out_carry;
        logic [3:0]   out_op;
        logic         out_err;
        logic         flag_c;
        logic [1:0]   flag_cmp;
        logic [W-1:0] alu_a;
        logic [W-1:0] alu_b;
        logic [3:0]   alu_op;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [3:0]   in_op = 4'd0;
    logic         out_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    obs_t o [2];
    obs_t cap [2];
    obs_t rel [2];
    obs_t ex [2];
    int   lat [2];
    int   hold_bad [2];
    int   sc [2] = '{1, 3};

    logic         m_fc [2];
    logic [1:0]   m_fcmp [2];
    logic [W-1:0] m_a [2];
    logic [W-1:0] m_b [2];
    logic [3:0]   m_op [2];

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(W)) if1 ();
    alu_issue_ctrl_if #(.WIDTH(W)) if3 ();

    alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    // ALU behaviour: returns {carry, comp, result}; comp 00 equal, 01 a>b, 10 a<b.
    function automatic logic [W+2:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
        logic [W:0] s;
        logic [1:0] cmp;
        cmp = (a == b) ? 2'b00 : ((a > b) ? 2'b01 : 2'b10);
        case (op)
            4'd0, 4'd1:       s = {1'b0, a} + {1'b0, b};
            4'd2, 4'd3, 4'd8: s = {(a >= b), a - b};
            4'd4:             s = {1'b0, a & b};
            4'd5:             s = {1'b0, a | b};
            4'd6:             s = {1'b0, a ^ b};
            4'd7:             s = {1'b0, ~a};
            default:          s = '0;
        endcase
        return {s[W], cmp, s[W-1:0]};
    endfunction

    assign if1.in_valid  = in_valid;
    assign if1.in_a      = in_a;
    assign if1.in_b      = in_b;
    assign if1.in_op     = in_op;
    assign if1.out_ready = out_ready;
    assign if3.in_valid  = in_valid;
    assign if3.in_a      = in_a;
    assign if3.in_b      = in_b;
    assign if3.in_op     = in_op;
    assign if3.out_ready = out_ready;

    assign {if1.alu_carry, if1.alu_comp, if1.alu_result} = alu_fn(if1.alu_a, if1.alu_b, if1.alu_op_code);
    assign {if3.alu_carry, if3.alu_comp, if3.alu_result} = alu_fn(if3.alu_a, if3.alu_b, if3.alu_op_code);

    assign o[0] = {if1.in_ready, if1.out_valid, if1.out_result, if1.out_comp, if1.out_carry, if1.out_op,
                   if1.out_err, if1.flag_c, if1.flag_cmp, if1.alu_a, if1.alu_b, if1.alu_op_code};
    assign o[1] = {if3.in_ready, if3.out_valid, if3.out_result, if3.out_comp, if3.out_carry, if3.out_op,
                   if3.out_err, if3.flag_c, if3.flag_cmp, if3.alu_a, if3.alu_b, if3.alu_op_code};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_fc[d] = 1'b0; m_fcmp[d] = 2'd0; m_a[d] = '0; m_b[d] = '0; m_op[d] = 4'd0;
        end
    endtask

    // Expected snapshot of a DUT at the moment its response first becomes valid.
    function automatic obs_t predict(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [3:0] op);
        obs_t e;
        logic [W+2:0] r;
        e = '0;
        e.out_valid = 1'b1;
        e.out_op = op;
        if (op > 4'd8) begin
            e.out_err = 1'b1;
        end else begin
            r = alu_fn(a, b, op);
            {e.out_carry, e.out_comp, e.out_result} = r;
            m_a[d] = a; m_b[d] = b; m_op[d] = op;
            if (op == 4'd0 || op == 4'd2) m_fc[d] = r[W+2];
            if (op == 4'd8) m_fcmp[d] = r[W+1:W];
        end
        e.flag_c = m_fc[d]; e.flag_cmp = m_fcmp[d];
        e.alu_a = m_a[d]; e.alu_b = m_b[d]; e.alu_op = m_op[d];
        return e;
    endfunction

    function automatic int exp_lat(input int d, input logic [3:0] op);
        return (op > 4'd8) ? 1 : sc[d] + 1;
    endfunction

    // Issue one command to both DUTs; records first-valid snapshot and latency in edges
    // counted from the accept edge (accept edge = 1). hold>0 keeps out_ready low that long.
    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                           input int hold);
        int seen [2];
        seen = '{0, 0};
        lat = '{-1, -1};
        hold_bad = '{0, 0};
        @(negedge clk);
        for (int i = 0; i < 20 && !(o[0].in_ready && o[1].in_ready); i++) @(negedge clk);
        checks++;
        if (!(o[0].in_ready && o[1].in_ready)) begin
            failures++;
            $display("FAIL idle_wait in_ready=%b%b want 11", o[0].in_ready, o[1].in_ready);
        end
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; out_ready = (hold == 0);
        for (int e = 1; e <= 40 && !(seen[0] != 0 && seen[1] != 0); e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                in_valid = (hold != 0); in_a = $urandom; in_b = $urandom; in_op = 4'($urandom);
            end
            for (int d = 0; d < 2; d++)
                if (seen[d] == 0 && o[d].out_valid) begin seen[d] = 1; lat[d] = e; cap[d] = o[d]; end
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                for (int d = 0; d < 2; d++) if (o[d] !== cap[d]) hold_bad[d]++;
            end
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b0;
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) rel[d] = o[d];
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o[d] !== '0) begin failures++; $display("FAIL reset_state dut%0d got %h want 0", d, o[d]); end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o[d].in_ready !== 1'b1 || o[d].out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_release dut%0d in_ready=%b out_valid=%b want 1/0", d, o[d].in_ready, o[d].out_valid);
            end
        end
        model_reset();
    endtask

    task automatic test_add();
        for (int d = 0; d < 2; d++) ex[d] = predict(d, 35, 25, 4'b0001);
        run_cmd(35, 25, 4'b0001, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lat[d] != sc[d] + 1) begin failures++; $display("FAIL add_latency dut%0d got %0d want %0d", d, lat[d], sc[d] + 1); end
            checks++;
            if (cap[d].out_result !== 32'd60 || cap[d].out_err !== 1'b0) begin
                failures++; $display("FAIL add_result dut%0d got %0d err=%b want 60 err=0", d, cap[d].out_result, cap[d].out_err);
            end
            checks++;
            if (cap[d] !== ex[d]) begin failures++; $display("FAIL add_snapshot dut%0d got %h want %h", d, cap[d], ex[d]); end
        end
    endtask

    task automatic test_adcs();
        for (int d = 0; d < 2; d++) ex[d] = predict(d, 32'hFFFF_FFFF, 32'd1, 4'b0000);
        run_cmd(32'hFFFF_FFFF, 32'd1, 4'b0000, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lat[d] != sc[d] + 1) begin failures++; $display("FAIL adcs_latency dut%0d got %0d want %0d", d, lat[d], sc[d] + 1); end
            checks++;
            if (cap[d].out_result !== 32'd0 || cap[d].flag_c !== 1'b1 || cap[d].out_carry !== 1'b1) begin
                failures++;
                $display("FAIL adcs_carry dut%0d result=%h flag_c=%b carry=%b want 0/1/1", d, cap[d].out_result, cap[d].flag_c, cap[d].out_carry);
            end
        end
    endtask

    task automatic test_subs_hold();
        for (int d = 0; d < 2; d++) ex[d] = predict(d, 35, 25, 4'b0011);
        run_cmd(35, 25, 4'b0011, 5);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cap[d].out_result !== 32'd10 || cap[d] !== ex[d]) begin
                failures++; $display("FAIL subs_result dut%0d got %h want %h", d, cap[d], ex[d]);
            end
            checks++;
            if (hold_bad[d] != 0) begin failures++; $display("FAIL subs_hold_stable dut%0d unstable_cycles=%0d want 0", d, hold_bad[d]); end
            checks++;
            if (rel[d].out_valid !== 1'b0 || rel[d].out_result !== 32'd10 || rel[d].in_ready !== 1'b1) begin
                failures++;
                $display("FAIL subs_release dut%0d valid=%b result=%0d in_ready=%b want 0/10/1", d, rel[d].out_valid, rel[d].out_result, rel[d].in_ready);
            end
        end
    endtask

    task automatic test_cmp_flags();
        logic [W+2:0] r;
        r = alu_fn(35, 25, 4'b1000);
        for (int d = 0; d < 2; d++) ex[d] = predict(d, 35, 25, 4'b1000);
        run_cmd(35, 25, 4'b1000, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cap[d].flag_cmp !== r[W+1:W] || cap[d] !== ex[d]) begin
                failures++; $display("FAIL cmp_flag dut%0d got %h want %h", d, cap[d], ex[d]);
            end
        end
        for (int d = 0; d < 2; d++) ex[d] = predict(d, 1, 1, 4'b0001);
        run_cmd(1, 1, 4'b0001, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cap[d].flag_cmp !== r[W+1:W] || cap[d].flag_c !== 1'b1 || cap[d] !== ex[d]) begin
                failures++; $display("FAIL add_keeps_flags dut%0d got %h want %h", d, cap[d], ex[d]);
            end
        end
    endtask

    task automatic test_illegal();
        for (int d = 0; d < 2; d++) ex[d] = predict(d, 32'h1234, 32'h5678, 4'b1010);
        run_cmd(32'h1234, 32'h5678, 4'b1010, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lat[d] != 1) begin failures++; $display("FAIL illegal_latency dut%0d got %0d want 1", d, lat[d]); end
            checks++;
            if (cap[d].out_err !== 1'b1 || cap[d].out_result !== '0 || cap[d].alu_op !== 4'b0001 || cap[d] !== ex[d]) begin
                failures++; $display("FAIL illegal_response dut%0d got %h want %h", d, cap[d], ex[d]);
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        @(negedge clk);
        for (int i = 0; i < 20 && !(o[0].in_ready && o[1].in_ready); i++) @(negedge clk);
        in_valid = 1'b1; in_a = 32'd7; in_b = 32'd9; in_op = 4'b0000; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o[d] !== '0) begin failures++; $display("FAIL reset_mid_clear dut%0d got %h want 0", d, o[d]); end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o[d].out_valid !== 1'b0 || o[d].in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_mid_after dut%0d cyc%0d valid=%b in_ready=%b want 0/1", d, c, o[d].out_valid, o[d].in_ready);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [3:0]   op;
        int           hold;
        for (int n = 0; n < 40; n++) begin
            a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = 4'($urandom_range(0, 15)); hold = $urandom_range(0, 2);
            for (int d = 0; d < 2; d++) ex[d] = predict(d, a, b, op);
            run_cmd(a, b, op, hold);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (lat[d] != exp_lat(d, op)) begin
                    failures++; $display("FAIL rand_latency n%0d dut%0d op=%h got %0d want %0d", n, d, op, lat[d], exp_lat(d, op));
                end
                checks++;
                if (cap[d] !== ex[d]) begin failures++; $display("FAIL rand_snapshot n%0d dut%0d got %h want %h", n, d, cap[d], ex[d]); end
                if (hold > 0) begin
                    checks++;
                    if (hold_bad[d] != 0 || rel[d].out_valid !== 1'b0) begin
                        failures++; $display("FAIL rand_hold n%0d dut%0d unstable=%0d valid_after=%b want 0/0", n, d, hold_bad[d], rel[d].out_valid);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_adcs();
        test_subs_hold();
        test_cmp_flags();
        test_illegal();
        test_reset_mid_drive();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
